uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the PIC18F45k22 link, 8N1 at 115200 baud on the 25 MHz clock. Sits directly upstream of the UART command decoder: it deserialises the `rx` pin and delivers each received byte as a one-cycle `from_uart_valid` strobe with `from_uart_data`. It also flags framing errors so bad frames are never passed on.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per bit (25 MHz / 115200, truncated).
- `HALF_BIT`, 108, cycles from the detected start edge to the start-bit mid-sample (`CLKS_PER_BIT/2`).
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rx`  in  1  asynchronous serial input; idles high.
- `from_uart_valid`  out  1  one-cycle strobe; `from_uart_data` holds a good byte.
- `from_uart_data`  out  8  last good received byte; held until the next good byte.
- `frame_err`  out  1  one-cycle strobe; the stop bit was sampled low.

## Operation
- Input synchroniser: two flops on `rx`, both reset to 1. All logic uses the second-flop output `rx_s` only.
- Counters: `bit_cnt` is 8 bits and counts 0..CLKS_PER_BIT-1. `bit_idx` is 3 bits. Shift register `shreg` is 8 bits, LSB first.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rx_s`==0, clear `bit_cnt` and go to START.
  - START: when `bit_cnt`==HALF_BIT-1, sample `rx_s`. If 0, clear `bit_cnt` and `bit_idx`, then go to DATA. If 1 (glitch), go to IDLE with no strobe.
  - DATA: when `bit_cnt`==CLKS_PER_BIT-1, shift `rx_s` into `shreg[7]` (right shift) and clear `bit_cnt`. If `bit_idx`==7, go to STOP; otherwise increment `bit_idx`.
  - STOP: when `bit_cnt`==CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: load `from_uart_data` <= `shreg`, pulse `from_uart_valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `from_uart_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line (break) produces exactly one `frame_err` and no further strobes.
- Every sample point is a bit centre. Return to IDLE happens at the stop-bit centre, so a following start edge half a bit later is caught.
- No backpressure. The consumer samples every cycle, and `from_uart_valid` is never held more than one cycle.
- `from_uart_valid` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values: `from_uart_valid`=0, `from_uart_data`=8'h00, `frame_err`=0, FSM=IDLE, counters=0, sync flops=1.
- Reset is asynchronous. Asserting `rst` mid-frame aborts the frame immediately with no strobe. After release, the block re-arms in IDLE and needs a fresh falling edge.
- Latency: the falling edge on `rx` is seen in IDLE 2 cycles later (synchroniser). From that edge to the `from_uart_valid` rising edge is 2 + HALF_BIT + 9×CLKS_PER_BIT = 2063 cycles, ±1.
- `from_uart_valid` is high for exactly 1 cycle per good frame. Minimum spacing between strobes is 10 bit times (2170 cycles) for back-to-back frames.
- `frame_err` has the same timing as `from_uart_valid`.
- Baud tolerance: frames from a transmitter within ±2% of 115200 are received correctly. The truncation error of 217 vs 217.01 is negligible.
- Counter widths: `bit_cnt` never exceeds CLKS_PER_BIT-1 and has no wrap path. `bit_idx` wraps only on DATA→STOP, where it is cleared on the next START.

## Test plan
- Single byte 0x24 at 115200 → one `from_uart_valid` 2063±1 cycles after the start edge, `from_uart_data`=0x24, `frame_err` stays 0.
- Back-to-back string "$05" (0x24, 0x30, 0x35) with no idle gap → three strobes carrying 0x24, 0x30, 0x35 in order, spaced 2170±1 cycles. The data bus holds 0x35 afterwards.
- `rx` glitch low for 50 cycles → no `from_uart_valid` and no `frame_err`. A following 0x9A frame is received as 0x9A.
- Frame 0x55 with the stop bit driven low, then `rx` held low for 5000 cycles → exactly one `frame_err` pulse, no `from_uart_valid`, `from_uart_data` unchanged. After `rx` returns high, a 0x23 frame yields `from_uart_data`=0x23.
- `rst` asserted (0) during data bit 4 of a frame → outputs at reset values within the same cycle, no strobe. After release, an idle period and then frame 0x9A → one strobe with 0x9A.
- Transmitter baud at +2% and at -2% sending 0xA5 and 0x00 → both received correctly, no `frame_err`.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side byte bus from uart_rx to the UART command decoder.
//   from_uart_valid : one-cycle strobe, from_uart_data holds a good byte
//   from_uart_data  : last good received byte, held until the next one
//   frame_err       : one-cycle strobe, stop bit was sampled low
// master = receiver (drives), slave = consumer (samples every cycle).
interface uart_rx_if;
  logic       from_uart_valid;
  logic [7:0] from_uart_data;
  logic       frame_err;

  modport master (
    output from_uart_valid,
    output from_uart_data,
    output frame_err
  );

  modport slave (
    input from_uart_valid,
    input from_uart_data,
    input frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver for the PIC18F45k22 link (115200 baud on 25 MHz).
// Deserialises rx and delivers each good byte as a one-cycle strobe on the
// bus; frames with a low stop bit raise frame_err instead and are dropped.
//   clk : system clock, 25 MHz
//   rst : asynchronous active-low reset (0 = reset)
//   rx  : asynchronous serial input, idles high
//   bus : uart_rx_if.master (from_uart_valid, from_uart_data, frame_err)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic              rx_meta;
  logic              rx_s;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state and datapath; every sample is taken at a bit centre.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          if (!rx_s) begin
            bit_cnt_d = '0;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
          bit_cnt_d = '0;
          // Index wraps 7 -> 0 on the way to STOP; START clears it anyway.
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        // Hold off until the line is released so a break yields one error.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.from_uart_valid = valid_q;
  assign bus.from_uart_data  = data_q;
  assign bus.frame_err       = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: single byte latency, back-to-back string,
// glitch rejection, framing error with break, mid-frame reset, +/-2% baud.
`timescale 1ns / 1ps
module tb_uart_rx;

  localparam real CLK_NS = 40.0;
  localparam real BIT_NS = 217.0 * CLK_NS;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned t_start  = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  logic [7:0]  q_data[$];
  int unsigned q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.from_uart_valid === 1'b1) begin
      q_data.push_back(bus.from_uart_data);
      q_cyc.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.from_uart_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, then leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
    t_start = cyc;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  int unsigned base;
  int unsigned fbase;
  int unsigned d;
  logic [7:0]  data_before;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rx  = 1'b1;
    rst = 1'b0;
    wait_cycles(5);
    check("rst_valid", 32'(bus.from_uart_valid), 32'h0);
    check("rst_data",  32'(bus.from_uart_data),  32'h00);
    check("rst_ferr",  32'(bus.frame_err),       32'h0);
    rst = 1'b1;
    wait_cycles(20);

    // Single byte with latency check.
    base = q_data.size();
    send_frame(8'h24, 1'b1, BIT_NS);
    wait_cycles(300);
    check("t1_count", 32'(q_data.size() - base), 32'd1);
    if (q_data.size() > base) begin
      check("t1_data", 32'(q_data[base]), 32'h24);
      d = q_cyc[base] - t_start;
      check("t1_latency_2063pm1", 32'(d >= 2062 && d <= 2064), 32'd1);
    end
    check("t1_ferr", 32'(ferr_cnt), 32'd0);

    // Back-to-back "$05" with no idle gap.
    base = q_data.size();
    send_frame(8'h24, 1'b1, BIT_NS);
    send_frame(8'h30, 1'b1, BIT_NS);
    send_frame(8'h35, 1'b1, BIT_NS);
    wait_cycles(300);
    check("t2_count", 32'(q_data.size() - base), 32'd3);
    if (q_data.size() >= base + 3) begin
      check("t2_data0", 32'(q_data[base]),     32'h24);
      check("t2_data1", 32'(q_data[base + 1]), 32'h30);
      check("t2_data2", 32'(q_data[base + 2]), 32'h35);
      d = q_cyc[base + 1] - q_cyc[base];
      check("t2_space01", 32'(d >= 2169 && d <= 2171), 32'd1);
      d = q_cyc[base + 2] - q_cyc[base + 1];
      check("t2_space12", 32'(d >= 2169 && d <= 2171), 32'd1);
    end
    check("t2_hold", 32'(bus.from_uart_data), 32'h35);

    // Short low glitch must be rejected.
    base = q_data.size();
    rx = 1'b0;
    wait_cycles(50);
    rx = 1'b1;
    wait_cycles(300);
    check("t3_glitch_valid", 32'(q_data.size() - base), 32'd0);
    check("t3_glitch_ferr",  32'(ferr_cnt),             32'd0);
    send_frame(8'h9A, 1'b1, BIT_NS);
    wait_cycles(300);
    check("t3_count", 32'(q_data.size() - base), 32'd1);
    check("t3_data",  32'(bus.from_uart_data),   32'h9A);

    // Low stop bit followed by a held-low break.
    base = q_data.size();
    fbase = ferr_cnt;
    data_before = bus.from_uart_data;
    send_frame(8'h55, 1'b0, BIT_NS);
    wait_cycles(5000);
    check("t4_ferr_count", 32'(ferr_cnt - fbase),       32'd1);
    check("t4_no_valid",   32'(q_data.size() - base),   32'd0);
    check("t4_data_held",  32'(bus.from_uart_data),     32'(data_before));
    rx = 1'b1;
    wait_cycles(300);
    send_frame(8'h23, 1'b1, BIT_NS);
    wait_cycles(300);
    check("t4_after_count", 32'(q_data.size() - base), 32'd1);
    check("t4_after_data",  32'(bus.from_uart_data),   32'h23);
    check("t4_ferr_final",  32'(ferr_cnt - fbase),     32'd1);

    // Reset asserted during data bit 4.
    base = q_data.size();
    fbase = ferr_cnt;
    @(negedge clk);
    fork
      send_frame(8'h9A, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 5.5);
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.from_uart_valid), 32'h0);
        check("t5_rst_data",  32'(bus.from_uart_data),  32'h00);
        check("t5_rst_ferr",  32'(bus.frame_err),       32'h0);
      end
    join
    rx = 1'b1;
    wait_cycles(300);
    rst = 1'b1;
    wait_cycles(500);
    check("t5_no_strobe", 32'(q_data.size() - base), 32'd0);
    send_frame(8'h9A, 1'b1, BIT_NS);
    wait_cycles(300);
    check("t5_count", 32'(q_data.size() - base), 32'd1);
    check("t5_data",  32'(bus.from_uart_data),   32'h9A);
    check("t5_ferr",  32'(ferr_cnt - fbase),     32'd0);

    // Transmitter baud +2% (shorter bits) and -2% (longer bits).
    base = q_data.size();
    fbase = ferr_cnt;
    send_frame(8'hA5, 1'b1, BIT_NS / 1.02);
    wait_cycles(300);
    send_frame(8'h00, 1'b1, BIT_NS / 1.02);
    wait_cycles(300);
    send_frame(8'hA5, 1'b1, BIT_NS * 1.02);
    wait_cycles(300);
    send_frame(8'h00, 1'b1, BIT_NS * 1.02);
    wait_cycles(300);
    check("t6_count", 32'(q_data.size() - base), 32'd4);
    if (q_data.size() >= base + 4) begin
      check("t6_fast_a5", 32'(q_data[base]),     32'hA5);
      check("t6_fast_00", 32'(q_data[base + 1]), 32'h00);
      check("t6_slow_a5", 32'(q_data[base + 2]), 32'hA5);
      check("t6_slow_00", 32'(q_data[base + 3]), 32'h00);
    end
    check("t6_ferr", 32'(ferr_cnt - fbase), 32'd0);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
